mp_add_sequencer: RTL

MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

---
 rtl/mp_add_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer
// Multi-precision add/subtract of up to 4 x 64-bit limbs. A single 64-bit
// prefix adder is reused once per limb, least-significant limb first, with
// the carry held in a register between limbs.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present
//   in_ready   : request accepted when in_valid && in_ready on an edge
//   op_a, op_b : 256-bit operands, limb 0 = bits [63:0]
//   sub        : 0 = A+B, 1 = A-B
//   nlimbs     : active limb count minus 1
//   out_valid  : result present
//   out_ready  : result consumed when out_valid && out_ready on an edge
//   sum        : result, limbs above nlimbs read 0
//   carry_out  : carry out of the top active limb (sub: 1 = no borrow)
//   ovf        : signed overflow at the top active limb's MSB
//   busy       : operation in progress or result waiting
// ---------------------------------------------------------------------------
module mp_add_sequencer #(
    parameter int LIMBS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] op_a,
    input  logic [255:0] op_b,
    input  logic         sub,
    input  logic [1:0]   nlimbs,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] sum,
    output logic         carry_out,
    output logic         ovf,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [255:0]   a_q, a_d;
    logic [255:0]   b_q, b_d;
    logic [1:0]     nlimbs_q, nlimbs_d;
    logic [1:0]     idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [255:0]   sum_q, sum_d;
    logic           carry_out_q, carry_out_d;
    logic           ovf_q, ovf_d;

    logic [63:0]    add_a, add_b, add_s;
    logic           add_cout;

    // Operand limb selected by the running index; bit offset = idx * 64.
    assign add_a = a_q[{idx_q, 6'b0} +: 64];
    assign add_b = b_q[{idx_q, 6'b0} +: 64];

    top_module_ladner64 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        nlimbs_d    = nlimbs_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = RUN;
                    a_d         = op_a;
                    // Subtraction is A + ~B + 1: invert B here, inject the
                    // +1 as the initial carry.
                    b_d         = sub ? ~op_b : op_b;
                    nlimbs_d    = nlimbs;
                    carry_d     = sub;
                    idx_d       = 2'd0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            RUN: begin
                sum_d[{idx_q, 6'b0} +: 64] = add_s;
                carry_d = add_cout;
                if (idx_q == nlimbs_q) begin
                    state_d     = DONE;
                    carry_out_d = add_cout;
                    ovf_d       = (add_a[63] == add_b[63]) && (add_s[63] != add_a[63]);
                    // Park the index at 0 so it never wraps past the top limb.
                    idx_d       = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            nlimbs_q    <= 2'd0;
            idx_q       <= 2'd0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            nlimbs_q    <= nlimbs_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign ovf       = ovf_q;

endmodule

// ---------------------------------------------------------------------------
// top_module_ladner64
// 64-bit Ladner-Fischer (divide-and-conquer) parallel-prefix adder.
// Ports: a, b operands; cin carry in; s sum; cout carry out of bit 63.
// The carry-in is folded into the bit-0 generate so the prefix tree output
// at bit i is directly the carry into bit i+1.
// ---------------------------------------------------------------------------
module top_module_ladner64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] s,
    output logic        cout
);

    logic [63:0]      hp, hg;
    logic [6:0][63:0] g_l;
    logic [5:0][63:0] p_l;

    assign hp     = a ^ b;
    assign hg     = a & b;
    assign g_l[0] = {hg[63:1], hg[0] | (hp[0] & cin)};
    assign p_l[0] = hp;

    // Level gi: every bit whose bit gi is set merges with the last bit of
    // the preceding 2^gi-wide block.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_level
            for (gj = 0; gj < 64; gj++) begin : g_bit
                localparam int J_IDX = ((gj >> gi) << gi) - 1;
                if (((gj >> gi) & 1) == 1) begin : g_merge
                    assign g_l[gi+1][gj] = g_l[gi][gj] | (p_l[gi][gj] & g_l[gi][J_IDX]);
                    if (gi < 5) begin : g_pm
                        assign p_l[gi+1][gj] = p_l[gi][gj] & p_l[gi][J_IDX];
                    end
                end else begin : g_pass
                    assign g_l[gi+1][gj] = g_l[gi][gj];
                    if (gi < 5) begin : g_pp
                        assign p_l[gi+1][gj] = p_l[gi][gj];
                    end
                end
            end
        end
    endgenerate

    assign s    = hp ^ {g_l[6][62:0], cin};
    assign cout = g_l[6][63];

endmodule
